// File: rtl/vga_timing_generator.sv
// VGA raster timing: x/y scan counters with registered sync, blanking
// and line/frame markers one pixel clock behind the counters.
module vga_timing_generator #(
  parameter int PIXEL_BITWIDTH  = 11,
  parameter int RGB_BITWIDTH    = 8,
  parameter int H_VISIBLE       = 640,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_VISIBLE       = 480,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_vga_reset_n,
  output logic [PIXEL_BITWIDTH-1:0] o_vga_x,
  output logic [PIXEL_BITWIDTH-1:0] o_vga_y,
  input  logic [RGB_BITWIDTH-1:0]   i_red,
  input  logic [RGB_BITWIDTH-1:0]   i_green,
  input  logic [RGB_BITWIDTH-1:0]   i_blue,
  output logic [RGB_BITWIDTH-1:0]   o_red,
  output logic [RGB_BITWIDTH-1:0]   o_green,
  output logic [RGB_BITWIDTH-1:0]   o_blue,
  output logic                      o_hsync,
  output logic                      o_vsync,
  output logic                      o_visible,
  output logic                      o_line_start,
  output logic                      o_frame_start
);

  localparam int PW = PIXEL_BITWIDTH;
  localparam int RW = RGB_BITWIDTH;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [PW-1:0] H_LAST  = PW'(H_TOTAL - 1);
  localparam logic [PW-1:0] V_LAST  = PW'(V_TOTAL - 1);
  localparam logic [PW-1:0] H_VIS   = PW'(H_VISIBLE);
  localparam logic [PW-1:0] V_VIS   = PW'(V_VISIBLE);
  localparam logic [PW-1:0] HS_BEG  = PW'(H_VISIBLE + H_FRONT);
  localparam logic [PW-1:0] HS_END  = PW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [PW-1:0] VS_BEG  = PW'(V_VISIBLE + V_FRONT);
  localparam logic [PW-1:0] VS_END  = PW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [PW-1:0] ZERO    = '0;

  localparam logic SYNC_OFF = (SYNC_ACTIVE_LOW != 0);

  logic [PW-1:0] x;
  logic [PW-1:0] y;
  logic          x_last;
  logic          y_last;
  logic          active_c;
  logic          hs_c;
  logic          vs_c;
  logic          line_c;
  logic          frame_c;

  assign o_vga_x = x;
  assign o_vga_y = y;

  // Decode raster position into blanking, sync and marker terms.
  always_comb begin
    x_last   = (x == H_LAST);
    y_last   = (y == V_LAST);
    active_c = (x < H_VIS) && (y < V_VIS);
    hs_c     = (x >= HS_BEG) && (x < HS_END);
    vs_c     = (y >= VS_BEG) && (y < VS_END);
    line_c   = (x == ZERO) && (y < V_VIS);
    frame_c  = (x == ZERO) && (y == ZERO);
  end

  // Scan counters; the line-buffer hold parks the raster at (0,0).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      x <= '0;
      y <= '0;
    end else if (!i_vga_reset_n) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_last ? '0 : x + 1'b1;
      if (x_last) begin
        y <= y_last ? '0 : y + 1'b1;
      end
    end
  end

  // Pin register: one clock behind the counters, blank while held.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
      o_hsync       <= SYNC_OFF;
      o_vsync       <= SYNC_OFF;
      o_visible     <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else if (!i_vga_reset_n) begin
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
      o_hsync       <= SYNC_OFF;
      o_vsync       <= SYNC_OFF;
      o_visible     <= 1'b0;
      o_line_start  <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      o_red         <= active_c ? i_red : {RW{1'b0}};
      o_green       <= active_c ? i_green : {RW{1'b0}};
      o_blue        <= active_c ? i_blue : {RW{1'b0}};
      o_hsync       <= hs_c ^ SYNC_OFF;
      o_vsync       <= vs_c ^ SYNC_OFF;
      o_visible     <= active_c;
      o_line_start  <= line_c;
      o_frame_start <= frame_c;
    end
  end

endmodule
